load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit in the execute/memory path of the RISC-V core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It drives a word-wide data-memory bus with a request/ready handshake, and returns sign- or zero-extended load data plus a fault code. Byte/half/word alignment, lane steering and a bounded wait for memory are handled here so the ALU and register file stay purely combinational.

## Interface
- TIMEOUT_CYCLES, 255: max cycles memReq may wait for memReady before aborting; legal range 1..65535
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch an access; sampled only in IDLE
- isStore  in  1  1 = store, 0 = load; captured with start
- funct3  in  3  RV32I width/sign code; captured with start
- address  in  32  effective address (ALU result); captured with start
- storeData  in  32  rs2 value; captured with start
- memReady  in  1  memory accepts/completes the current request
- memRdata  in  32  aligned read word; valid when memReady=1 on a load
- memReq  out  1  request valid
- memWe  out  1  write enable, qualified by memReq
- memAddr  out  32  word address, bits [1:0] always 0
- memWdata  out  32  lane-replicated store data
- memByteEn  out  4  byte lane enables
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- loadData  out  32  extended load result; held until the next done
- fault  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done, held afterwards

## Operation
- States: IDLE, REQ, DONE.
- IDLE: when start=1, capture all inputs and decode, then pick one of:
  - illegal funct3 → DONE with fault=10, no bus activity
  - misaligned → DONE with fault=01, no bus activity
  - otherwise → REQ
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - any other value is illegal, including 100/101 with isStore=1
- Misaligned: half access with address[0]=1; word access with address[1:0]≠00.
- REQ: memReq=1. memWe, memAddr, memWdata and memByteEn hold stable until memReady=1. Wait counter starts at 0 on entry and increments each cycle memReady=0.
  - memReady=1: the access completes. For a load, capture loadData. Go to DONE with fault=00.
  - counter reaches TIMEOUT_CYCLES with memReady=0: go to DONE with fault=11, loadData unchanged.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE and REQ.
- Width rules (off = address[1:0]):
  - memAddr = {address[31:2],2'b00}
  - SB: byteEn = 0001<<off, wdata = {4{storeData[7:0]}}
  - SH: byteEn = 0011<<off, wdata = {2{storeData[15:0]}}
  - SW: byteEn = 1111, wdata = storeData
  - Loads: byteEn = 1111. Shift memRdata right by 8·off, then take [7:0] or [15:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU. LW takes the word unchanged.
- Bus outputs other than memReq may hold stale values while memReq=0.

## Timing
- Reset values:
  - memReq 0, memWe 0, memAddr 0, memWdata 0, memByteEn 0
  - busy 0, done 0, loadData 0, fault 00, state IDLE, counter 0
- Reset asserted mid-access drops memReq asynchronously. No completion or done follows.
- All outputs are registered.
- start sampled at edge E:
  - memReq rises after E
  - if memReady=1 at edge E+1: done is high in the following cycle, so minimum latency is 2 cycles from start to done
  - each wait cycle adds 1
- Faults detected at decode: done in the cycle after E, 1-cycle latency.
- Timeout: TIMEOUT_CYCLES wait cycles in REQ, then DONE.
- memReady outside REQ is ignored.
- A start held high through DONE launches a new access only from IDLE, so two done pulses are always separated by at least one cycle.
- busy falls in the same cycle done falls.

## Test plan
- LB address 0x1003, memRdata 0x80FF_1234, memReady=1 on first REQ cycle → memAddr 0x1000, byteEn 1111, done 2 cycles after start, loadData 0xFFFF_FF80, fault 00.
- SH address 0x2002, storeData 0x0000_ABCD, memReady delayed 3 cycles → memWe=1, byteEn 1100, wdata 0xABCD_ABCD stable all 4 REQ cycles, done once.
- LHU address 0x0001 → no memReq ever, done 1 cycle after start, fault 01. Repeat with funct3=011 → fault 10.
- TIMEOUT_CYCLES=4, LW with memReady held 0 → memReq high exactly 4 cycles, then done with fault 11, loadData still holds the previous value.
- start pulsed during REQ, and memReady pulsed in IDLE → both ignored, one transaction only.
- rst_n dropped mid-REQ → memReq, busy and done 0 immediately. After release, the next LW 0x10 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: alignment, lane steering, bounded memory wait
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                launch an access (sampled in IDLE only)
//   isStore, funct3      access kind and RV32I width/sign code
//   address, storeData   effective address and rs2 store data
//   memReady, memRdata   memory handshake and aligned read word
//   memReq, memWe        request valid and write enable
//   memAddr, memWdata    word address and lane-replicated store data
//   memByteEn            byte lane enables
//   busy, done           activity flag and one-cycle completion pulse
//   loadData, fault      extended load result and fault code (held after done)
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic        memReady,
    input  logic [31:0] memRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEn,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
    localparam logic [1:0] FAULT_FUNCT3  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    // The last wait cycle is the one where the counter already holds
    // TIMEOUT_CYCLES-1; that way memReq stays up exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic [2:0]  f3_q, f3_n;
    logic [1:0]  off_q, off_n;
    logic        mem_req_n, mem_we_n, busy_n, done_n;
    logic [31:0] mem_addr_n, mem_wdata_n, load_data_n;
    logic [3:0]  byte_en_n;
    logic [1:0]  fault_n;

    // Decode of the inputs presented with start.
    logic legal, misaligned;
    always_comb begin
        legal = 1'b0;
        if (isStore) begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                     ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    end

    // Lane extraction of the returned word using the captured offset.
    logic [31:0] shifted, load_ext;
    always_comb begin
        shifted = memRdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = memRdata;
        endcase
    end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        f3_n        = f3_q;
        off_n       = off_q;
        mem_req_n   = memReq;
        mem_we_n    = memWe;
        mem_addr_n  = memAddr;
        mem_wdata_n = memWdata;
        byte_en_n   = memByteEn;
        load_data_n = loadData;
        fault_n     = fault;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!legal) begin
                        state_n = DONE;
                        fault_n = FAULT_FUNCT3;
                        done_n  = 1'b1;
                    end else if (misaligned) begin
                        state_n = DONE;
                        fault_n = FAULT_ALIGN;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = REQ;
                        wait_cnt_n = 16'd0;
                        f3_n       = funct3;
                        off_n      = address[1:0];
                        mem_req_n  = 1'b1;
                        mem_we_n   = isStore;
                        mem_addr_n = {address[31:2], 2'b00};
                        if (!isStore) begin
                            byte_en_n   = 4'b1111;
                            mem_wdata_n = storeData;
                        end else begin
                            case (funct3[1:0])
                                2'b00: begin
                                    byte_en_n   = 4'b0001 << address[1:0];
                                    mem_wdata_n = {4{storeData[7:0]}};
                                end
                                2'b01: begin
                                    byte_en_n   = 4'b0011 << address[1:0];
                                    mem_wdata_n = {2{storeData[15:0]}};
                                end
                                default: begin
                                    byte_en_n   = 4'b1111;
                                    mem_wdata_n = storeData;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                if (memReady) begin
                    if (!memWe) begin
                        load_data_n = load_ext;
                    end
                    state_n   = DONE;
                    fault_n   = FAULT_OK;
                    done_n    = 1'b1;
                    mem_req_n = 1'b0;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_n   = DONE;
                    fault_n   = FAULT_TIMEOUT;
                    done_n    = 1'b1;
                    mem_req_n = 1'b0;
                end else begin
                    wait_cnt_n = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 32'd0;
            memWdata  <= 32'd0;
            memByteEn <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            loadData  <= 32'd0;
            fault     <= FAULT_OK;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            f3_q      <= f3_n;
            off_q     <= off_n;
            memReq    <= mem_req_n;
            memWe     <= mem_we_n;
            memAddr   <= mem_addr_n;
            memWdata  <= mem_wdata_n;
            memByteEn <= byte_en_n;
            busy      <= busy_n;
            done      <= done_n;
            loadData  <= load_data_n;
            fault     <= fault_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] storeData = 32'd0;
    logic        memReady = 1'b0;
    logic [31:0] memRdata = 32'd0;
    logic        memReq, memWe, busy, done;
    logic [31:0] memAddr, memWdata, loadData;
    logic [3:0]  memByteEn;
    logic [1:0]  fault;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isStore(isStore),
        .funct3(funct3), .address(address), .storeData(storeData),
        .memReady(memReady), .memRdata(memRdata), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memByteEn(memByteEn), .busy(busy), .done(done),
        .loadData(loadData), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        bit          sn;
        bit          rn;
        logic [1:0]  ef;
        logic [31:0] eld;
        logic [3:0]  ebe;
        logic [31:0] ewd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] ld_model = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected result of one access from the ISA-level rules.
    function automatic void model(inout vec_t x, input logic [31:0] prev_ld);
        int size, off;
        bit ok;
        logic [31:0] word, mask, v;
        off  = int'(x.a % 4);
        ok   = x.st ? (x.f3 <= 3'd2) : (x.f3 != 3'd3 && x.f3 != 3'd6 && x.f3 != 3'd7);
        size = 1 << x.f3[1:0];
        x.eld = prev_ld;
        x.ebe = 4'h0;
        x.ewd = 32'd0;
        if (!ok)                     x.ef = 2'd2;
        else if (x.a % size != 0)    x.ef = 2'd1;
        else if (x.dly >= T)         x.ef = 2'd3;
        else                         x.ef = 2'd0;
        if (x.st) begin
            x.ebe = 4'(((1 << size) - 1) << off);
            x.ewd = (size == 1) ? {4{x.sd[7:0]}} : (size == 2) ? {2{x.sd[15:0]}} : x.sd;
        end else begin
            x.ebe = 4'hF;
            if (x.ef == 2'd0) begin
                word = x.rd >> (8 * off);
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                v = word & mask;
                if (!x.f3[2] && size < 4 && word[8 * size - 1]) v = v | ~mask;
                x.eld = v;
            end
        end
    endfunction

    task automatic run(input vec_t x, input string tag);
        int cyc, reqs, exp_lat, exp_reqs;
        bit got, stable, busy_ok;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        a0 = 0; w0 = 0; b0 = 0; we0 = 0;
        if (x.ef == 2'd1 || x.ef == 2'd2) begin exp_lat = 1; exp_reqs = 0; end
        else if (x.ef == 2'd3)            begin exp_lat = T + 1; exp_reqs = T; end
        else                              begin exp_lat = x.dly + 2; exp_reqs = x.dly + 1; end

        @(negedge clk);
        start = 1'b1; isStore = x.st; funct3 = x.f3; address = x.a;
        storeData = x.sd; memRdata = x.rd; memReady = x.rn;
        cyc = 0; reqs = 0; got = 0; stable = 1; busy_ok = 1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_ok = 0;
            if (done) got = 1;
            if (memReq) begin
                reqs++;
                if (reqs == 1) begin
                    a0 = memAddr; w0 = memWdata; b0 = memByteEn; we0 = memWe;
                end else if (a0 !== memAddr || w0 !== memWdata || b0 !== memByteEn || we0 !== memWe) begin
                    stable = 0;
                end
                memReady = (reqs > x.dly);
                start = x.sn;
            end else begin
                memReady = x.rn;
                start = 1'b0;
            end
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " req_cycles"}, reqs, exp_reqs);
        chk({tag, " fault"}, 32'(fault), 32'(x.ef));
        chk({tag, " loadData"}, loadData, x.eld);
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        if (exp_reqs > 0) begin
            chk({tag, " bus_stable"}, 32'(stable), 32'd1);
            chk({tag, " memWe"}, 32'(we0), 32'(x.st));
            chk({tag, " memAddr"}, a0, {x.a[31:2], 2'b00});
            chk({tag, " memByteEn"}, 32'(b0), 32'(x.ebe));
            if (x.st) chk({tag, " memWdata"}, w0, x.ewd);
        end
        @(negedge clk);
        chk({tag, " post_done"}, 32'(done), 32'd0);
        chk({tag, " post_busy"}, 32'(busy), 32'd0);
        chk({tag, " post_req"}, 32'(memReq), 32'd0);
        memReady = 1'b0;
        start = 1'b0;
        ld_model = x.eld;
    endtask

    vec_t v[11];
    vec_t r;
    logic [2:0] legal_ld[5];

    initial begin
        legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2;
        legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;
        //        st f3      addr          sd            rd            dly sn rn ef eld            ebe    ewd
        v[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h80FF1234, 0, 0, 0, 2'd0, 32'hFFFFFF80, 4'hF, 32'h0};
        v[1]  = '{1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0,        3, 0, 0, 2'd0, 32'hFFFFFF80, 4'hC, 32'hABCDABCD};
        v[2]  = '{1'b0, 3'b101, 32'h0001, 32'h0,        32'h0,        0, 0, 0, 2'd1, 32'hFFFFFF80, 4'hF, 32'h0};
        v[3]  = '{1'b0, 3'b011, 32'h0001, 32'h0,        32'h0,        0, 0, 0, 2'd2, 32'hFFFFFF80, 4'hF, 32'h0};
        v[4]  = '{1'b0, 3'b010, 32'h0040, 32'h0,        32'hDEADBEEF, 9, 0, 0, 2'd3, 32'hFFFFFF80, 4'hF, 32'h0};
        v[5]  = '{1'b0, 3'b100, 32'h0002, 32'h0,        32'h80FF1234, 1, 1, 1, 2'd0, 32'h000000FF, 4'hF, 32'h0};
        v[6]  = '{1'b0, 3'b001, 32'h0002, 32'h0,        32'h80FF1234, 2, 0, 0, 2'd0, 32'hFFFF80FF, 4'hF, 32'h0};
        v[7]  = '{1'b1, 3'b000, 32'h0001, 32'h0000005A, 32'h0,        0, 1, 0, 2'd0, 32'hFFFF80FF, 4'h2, 32'h5A5A5A5A};
        v[8]  = '{1'b1, 3'b100, 32'h0000, 32'h0,        32'h0,        0, 0, 1, 2'd2, 32'hFFFF80FF, 4'h0, 32'h0};
        v[9]  = '{1'b0, 3'b010, 32'h0006, 32'h0,        32'h0,        0, 0, 0, 2'd1, 32'hFFFF80FF, 4'hF, 32'h0};
        v[10] = '{1'b0, 3'b010, 32'h0008, 32'h0,        32'hCAFEF00D, 3, 0, 0, 2'd0, 32'hCAFEF00D, 4'hF, 32'h0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset memReq", 32'(memReq), 0);
        chk("reset memWe", 32'(memWe), 0);
        chk("reset memAddr", memAddr, 0);
        chk("reset memWdata", memWdata, 0);
        chk("reset memByteEn", 32'(memByteEn), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset loadData", loadData, 0);
        chk("reset fault", 32'(fault), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(busy), 0);

        for (int i = 0; i < 11; i++) begin
            run(v[i], $sformatf("vec%0d", i));
        end

        // Reset dropped in the middle of a request.
        @(negedge clk);
        start = 1'b1; isStore = 1'b0; funct3 = 3'b010; address = 32'h20; memReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("midrst req_up", 32'(memReq), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst memReq", 32'(memReq), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst loadData", loadData, 0);
        ld_model = 32'd0;
        r = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0};
        model(r, ld_model);
        run(r, "after_reset");
        chk("after_reset value", loadData, 32'h12345678);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 150; n++) begin
            r.st  = 1'($urandom % 2);
            r.f3  = 3'($urandom_range(0, 7));
            if ($urandom % 4 != 0) begin
                r.f3 = r.st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            end
            r.a   = $urandom;
            if ($urandom % 2 == 0) r.a[1:0] = 2'b00;
            r.sd  = $urandom;
            r.rd  = $urandom;
            r.dly = $urandom_range(0, 5);
            r.sn  = 1'($urandom % 2);
            r.rn  = 1'($urandom % 2);
            model(r, ld_model);
            run(r, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
